// File: rtl/tt_um_wokwi_393815624518031361.sv
// tt_um_wokwi_393815624518031361
// Single 8-bit state register Q with four update modes selected by ui_in[7:6]:
//   00 LOAD  : Q <= {3'b000, D}
//   01 COUNT : Q <= Q + D (mod 256)
//   10 LFSR  : Q <= {Q[6:0], Q[7]^Q[5]^Q[4]^Q[3]}, with 0 escaping to 8'h01
//   11 SHIFT : Q <= {Q[6:0], D[0]}
// ui_in[5] is a global enable; when low, Q holds in every mode.
// uo_out is a straight copy of Q, so every update shows up one edge later.

module tt_um_wokwi_393815624518031361 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    // Field views of ui_in; sampled directly at the edge, no synchronizers.
    mode_e      mode;
    logic       en;
    logic [4:0] operand;

    assign mode    = mode_e'(ui_in[7:6]);
    assign en      = ui_in[5];
    assign operand = ui_in[4:0];

    logic [7:0] state_q;
    logic [7:0] state_d;
    logic       lfsr_fb;

    // Taps 8,6,5,4 give a maximal-length sequence; all-zero is its lock-up state.
    assign lfsr_fb = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];

    // Next-state selection from the current Q and the sampled control byte.
    always_comb begin
        // NOTE: default to hold so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (en) begin
            unique case (mode)
                MODE_LOAD:  state_d = {3'b000, operand};
                // Carry out of bit 7 is dropped by the 8-bit result width.
                MODE_COUNT: state_d = state_q + {3'b000, operand};
                MODE_LFSR:  state_d = (state_q == 8'h00) ? 8'h01
                                                         : {state_q[6:0], lfsr_fb};
                MODE_SHIFT: state_d = {state_q[6:0], operand[0]};
                default:    state_d = state_q;
            endcase
        end
    end

    // State register: cleared immediately by rst_n, otherwise loads state_d each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 8'h00;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, avoiding races.
            state_q <= state_d;
        end
    end

    // Output is the register itself; no combinational path from ui_in.
    assign uo_out = state_q;

endmodule

// File: tb/tb_tt_um_wokwi_393815624518031361.sv
// Directed bench for tt_um_wokwi_393815624518031361 with hand-computed expectations.

module tb_tt_um_wokwi_393815624518031361;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    int n_checks = 0;
    int n_pass   = 0;

    tt_um_wokwi_393815624518031361 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, actual, expected);
        end
    endtask

    // Present ui_in, take one rising edge, land 1 time unit after it.
    task automatic apply(input logic [7:0] v);
        ui_in = v;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; uo_out must clear without an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check(tag, uo_out, 8'h00);
        rst_n = 1'b1;
    endtask

    // ui_in encodings: {mode[1:0], en, D[4:0]}
    localparam logic [7:0] LOAD_15  = 8'b00_1_10101;
    localparam logic [7:0] HOLD     = 8'b00_0_11111;
    localparam logic [7:0] CNT_31   = 8'b01_1_11111;
    localparam logic [7:0] CNT_0    = 8'b01_1_00000;
    localparam logic [7:0] CNT_2    = 8'b01_1_00010;
    localparam logic [7:0] LFSR_EN  = 8'b10_1_00000;
    localparam logic [7:0] LFSR_DIS = 8'b10_0_00000;
    localparam logic [7:0] SH_1     = 8'b11_1_00001;
    localparam logic [7:0] SH_0     = 8'b11_1_00000;
    localparam logic [7:0] SH_0_HI  = 8'b11_1_11110;
    localparam logic [7:0] LOAD_03  = 8'b00_1_00011;

    logic [7:0] cnt_exp   [9] = '{8'h1F, 8'h3E, 8'h5D, 8'h7C, 8'h9B, 8'hBA, 8'hD9, 8'hF8, 8'h17};
    logic [7:0] lfsr_exp  [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic [7:0] sh_in     [4] = '{SH_1, SH_0, SH_1, SH_1};
    logic [7:0] sh_exp    [4] = '{8'h01, 8'h02, 8'h05, 8'h0B};

    initial begin
        rst_n = 1'b0;
        ui_in = 8'h00;
        #12;
        check("reset_state", uo_out, 8'h00);
        // Edges while held in reset must not update Q.
        ui_in = LOAD_15;
        @(posedge clk);
        #1;
        check("edge_in_reset", uo_out, 8'h00);
        rst_n = 1'b1;

        // LOAD then hold with en=0.
        apply(LOAD_15);
        check("load_15", uo_out, 8'h15);
        for (int i = 0; i < 3; i++) begin
            apply(HOLD);
            check($sformatf("hold_en0_%0d", i), uo_out, 8'h15);
        end
        // No combinational path: ui_in change without an edge.
        ui_in = LOAD_03;
        #2;
        check("no_comb_path", uo_out, 8'h15);

        // COUNT wrap from reset.
        do_reset("reset_before_count");
        for (int i = 0; i < 9; i++) begin
            apply(CNT_31);
            check($sformatf("count_edge%0d", i + 1), uo_out, cnt_exp[i]);
        end
        apply(CNT_0);
        check("count_d0_hold", uo_out, 8'h17);

        // Async reset mid-operation, then clocks while held.
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", uo_out, 8'h00);
        for (int i = 0; i < 2; i++) begin
            apply(CNT_31);
            check($sformatf("clk_in_reset_%0d", i), uo_out, 8'h00);
        end
        rst_n = 1'b1;

        // LFSR from Q=0 (lock-up escape first).
        for (int i = 0; i < 5; i++) begin
            apply(LFSR_EN);
            check($sformatf("lfsr_%0d", i), uo_out, lfsr_exp[i]);
        end
        apply(LFSR_DIS);
        check("lfsr_en0_hold", uo_out, 8'h11);

        // SHIFT from reset.
        do_reset("reset_before_shift");
        for (int i = 0; i < 4; i++) begin
            apply(sh_in[i]);
            check($sformatf("shift_%0d", i), uo_out, sh_exp[i]);
        end
        // D[4:1] are ignored: only D[0]=0 enters.
        apply(SH_0_HI);
        check("shift_ignore_hi", uo_out, 8'h16);

        // Mode switch applies on the edge it is sampled.
        do_reset("reset_before_switch");
        apply(LOAD_03);
        check("switch_load", uo_out, 8'h03);
        apply(CNT_2);
        check("switch_count", uo_out, 8'h05);
        apply(SH_1);
        check("switch_shift", uo_out, 8'h0B);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
